// File: rtl/uart_tx_if.sv
// Byte-write handshake and serial line of the UART transmitter.
// The bench or host drives the master side and uart_tx sits on the slave side.
interface uart_tx_if;
    logic       wr;
    logic [7:0] din;
    logic       rdy;
    logic       tx;
    logic       busy;

    modport master (output wr, output din, input rdy, input tx, input busy);
    modport slave  (input wr, input din, output rdy, output tx, output busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity and stop bits.
// Each bit lasts BIT_TIME clocks, and every output comes straight from a register.
module uart_tx #(
    parameter int BIT_TIME  = 417,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic rst,
    uart_tx_if.slave bus
);

    localparam int             CW        = $clog2(BIT_TIME);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(BIT_TIME - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]     DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic          tx_r;
    logic          rdy_r;
    logic          busy_r;
    logic          bit_end;

    assign bit_end  = (cnt == CNT_LAST);
    assign bus.tx   = tx_r;
    assign bus.rdy  = rdy_r;
    assign bus.busy = busy_r;

    // Parity is latched together with the byte so later din changes cannot affect the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx_r      <= 1'b1;
            rdy_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            if (state != S_IDLE)
                cnt <= bit_end ? '0 : cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (bus.wr) begin
                        shift_reg <= bus.din & DATA_MASK;
                        par_bit   <= (^(bus.din & DATA_MASK)) ^ PAR_ODD;
                        cnt       <= '0;
                        state     <= S_START;
                        tx_r      <= 1'b0;
                        rdy_r     <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state <= S_DATA;
                        tx_r  <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx_r  <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx_r  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_r    <= shift_reg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                        tx_r  <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= S_IDLE;
                            rdy_r    <= 1'b1;
                            busy_r   <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_r   <= 1'b1;
                    rdy_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
